// File: rtl/ureg.sv
// ----------------------------------------------------------------------------
// ureg -- universal register.
//
// A WIDTH-bit register with parallel load, shift left/right with a serial
// input, rotate left/right, and synchronous clear. A saturating counter
// tracks how many shift/rotate operations have happened since the last
// load or clear. done flags that a full word has been shifted through.
//
// Ports
//   ureg_port_clk    in   1      rising-edge clock
//   ureg_port_rst    in   1      asynchronous active-low reset
//   ureg_port_en     in   1      operation enable; low freezes all state
//   ureg_port_mode   in   3      operation select (see mode_e)
//   ureg_port_d      in   WIDTH  parallel load data
//   ureg_port_sin    in   1      serial input for the shift modes
//   ureg_oport_q     out  WIDTH  register contents
//   ureg_oport_sout  out  1      last bit shifted or rotated out
//   ureg_oport_cnt   out  CW     shifts/rotates since last load or clear
//   ureg_oport_done  out  1      high while cnt == WIDTH
// ----------------------------------------------------------------------------
module ureg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              CW      = $clog2(WIDTH + 1)
) (
    input  logic             ureg_port_clk,
    input  logic             ureg_port_rst,
    input  logic             ureg_port_en,
    input  logic [2:0]       ureg_port_mode,
    input  logic [WIDTH-1:0] ureg_port_d,
    input  logic             ureg_port_sin,
    output logic [WIDTH-1:0] ureg_oport_q,
    output logic             ureg_oport_sout,
    output logic [CW-1:0]    ureg_oport_cnt,
    output logic             ureg_oport_done
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_CLR  = 3'b110,
        MODE_RSVD = 3'b111
    } mode_e;

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    mode_e            mode;
    logic [WIDTH-1:0] q_q,    q_d;
    logic             sout_q, sout_d;
    logic [CW-1:0]    cnt_q,  cnt_d;
    logic [CW-1:0]    cnt_sat;

    assign mode = mode_e'(ureg_port_mode);

    // Count stops at WIDTH so done stays asserted through further shifts.
    assign cnt_sat = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        q_d    = q_q;
        sout_d = sout_q;
        cnt_d  = cnt_q;
        if (ureg_port_en) begin
            case (mode)
                MODE_LOAD: begin
                    q_d   = ureg_port_d;
                    cnt_d = '0;
                end
                MODE_SHL: begin
                    q_d    = {q_q[WIDTH-2:0], ureg_port_sin};
                    sout_d = q_q[WIDTH-1];
                    cnt_d  = cnt_sat;
                end
                MODE_SHR: begin
                    q_d    = {ureg_port_sin, q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                    cnt_d  = cnt_sat;
                end
                MODE_ROL: begin
                    q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    sout_d = q_q[WIDTH-1];
                    cnt_d  = cnt_sat;
                end
                MODE_ROR: begin
                    q_d    = {q_q[0], q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                    cnt_d  = cnt_sat;
                end
                MODE_CLR: begin
                    q_d    = RST_VAL;
                    sout_d = 1'b0;
                    cnt_d  = '0;
                end
                default: ; // hold and reserved codes keep state
            endcase
        end
    end

    always_ff @(posedge ureg_port_clk or negedge ureg_port_rst) begin
        if (!ureg_port_rst) begin
            q_q    <= RST_VAL;
            sout_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            q_q    <= q_d;
            sout_q <= sout_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ureg_oport_q    = q_q;
    assign ureg_oport_sout = sout_q;
    assign ureg_oport_cnt  = cnt_q;
    assign ureg_oport_done = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_ureg.sv
// ----------------------------------------------------------------------------
// tb_ureg -- directed, table-driven bench for ureg (WIDTH=8, RST_VAL=0).
// Each table row is applied for one clock and the registered outputs are
// compared 1 time unit after the rising edge. Asynchronous reset cases are
// written out by hand below the table.
// ----------------------------------------------------------------------------
module tb_ureg;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_CLR  = 3'b110;
    localparam logic [2:0] M_RSVD = 3'b111;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic [CW-1:0]    cnt;
    logic             done;

    typedef struct {
        logic             en;
        logic [2:0]       mode;
        logic [WIDTH-1:0] d;
        logic             sin;
        logic [WIDTH-1:0] q;
        logic             sout;
        logic [CW-1:0]    cnt;
        logic             done;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    ureg #(.WIDTH(WIDTH), .RST_VAL(8'h00)) dut (
        .ureg_port_clk   (clk),
        .ureg_port_rst   (rst_n),
        .ureg_port_en    (en),
        .ureg_port_mode  (mode),
        .ureg_port_d     (d),
        .ureg_port_sin   (sin),
        .ureg_oport_q    (q),
        .ureg_oport_sout (sout),
        .ureg_oport_cnt  (cnt),
        .ureg_oport_done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [WIDTH-1:0] eq,
                             input logic es, input logic [CW-1:0] ec, input logic ed);
        check({tag, ".q"},    32'(q),    32'(eq));
        check({tag, ".sout"}, 32'(sout), 32'(es));
        check({tag, ".cnt"},  32'(cnt),  32'(ec));
        check({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    task automatic add(input logic e, input logic [2:0] m, input logic [WIDTH-1:0] dd,
                       input logic s, input logic [WIDTH-1:0] eq, input logic es,
                       input logic [CW-1:0] ec, input logic ed);
        vec_t v;
        v.en = e; v.mode = m; v.d = dd; v.sin = s;
        v.q = eq; v.sout = es; v.cnt = ec; v.done = ed;
        vecs.push_back(v);
    endtask

    // Drive one operation, then sample just after the edge that executes it.
    task automatic step(input logic e, input logic [2:0] m, input logic [WIDTH-1:0] dd,
                        input logic s);
        en = e; mode = m; d = dd; sin = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = M_HOLD;
        d     = '0;
        sin   = 1'b0;

        // Load A5 and shift it out left: sout 1,0,1,0,0,1,0,1
        add(1, M_LOAD, 8'hA5, 0, 8'hA5, 0, 0, 0);
        add(1, M_SHL,  8'h00, 0, 8'h4A, 1, 1, 0);
        add(1, M_SHL,  8'h00, 0, 8'h94, 0, 2, 0);
        add(1, M_SHL,  8'h00, 0, 8'h28, 1, 3, 0);
        add(1, M_SHL,  8'h00, 0, 8'h50, 0, 4, 0);
        add(1, M_SHL,  8'h00, 0, 8'hA0, 0, 5, 0);
        add(1, M_SHL,  8'h00, 0, 8'h40, 1, 6, 0);
        add(1, M_SHL,  8'h00, 0, 8'h80, 0, 7, 0);
        add(1, M_SHL,  8'h00, 0, 8'h00, 1, 8, 1);
        // Load keeps sout; back-to-back rotate right then left
        add(1, M_LOAD, 8'h81, 0, 8'h81, 1, 0, 0);
        add(1, M_ROR,  8'h00, 0, 8'hC0, 1, 1, 0);
        add(1, M_ROL,  8'h00, 0, 8'h81, 1, 2, 0);
        // Enable low freezes everything whatever the mode
        add(1, M_LOAD, 8'h3C, 0, 8'h3C, 1, 0, 0);
        add(0, M_SHL,  8'h00, 1, 8'h3C, 1, 0, 0);
        add(0, M_SHL,  8'h00, 0, 8'h3C, 1, 0, 0);
        add(0, M_SHL,  8'h00, 1, 8'h3C, 1, 0, 0);
        add(0, M_SHL,  8'h00, 0, 8'h3C, 1, 0, 0);
        add(0, M_SHL,  8'h00, 1, 8'h3C, 1, 0, 0);
        add(0, M_LOAD, 8'hFF, 1, 8'h3C, 1, 0, 0);
        add(0, M_CLR,  8'h00, 0, 8'h3C, 1, 0, 0);
        add(1, M_ROL,  8'h00, 1, 8'h78, 0, 1, 0);   // sin ignored
        // Shift right past WIDTH: cnt saturates, data keeps moving
        add(1, M_LOAD, 8'hFF, 0, 8'hFF, 0, 0, 0);
        add(1, M_SHR,  8'h00, 0, 8'h7F, 1, 1, 0);
        add(1, M_SHR,  8'h00, 0, 8'h3F, 1, 2, 0);
        add(1, M_SHR,  8'h00, 0, 8'h1F, 1, 3, 0);
        add(1, M_SHR,  8'h00, 0, 8'h0F, 1, 4, 0);
        add(1, M_SHR,  8'h00, 0, 8'h07, 1, 5, 0);
        add(1, M_SHR,  8'h00, 0, 8'h03, 1, 6, 0);
        add(1, M_SHR,  8'h00, 0, 8'h01, 1, 7, 0);
        add(1, M_SHR,  8'h00, 0, 8'h00, 1, 8, 1);
        add(1, M_SHR,  8'h00, 0, 8'h00, 0, 8, 1);
        add(1, M_SHR,  8'h00, 0, 8'h00, 0, 8, 1);
        add(1, M_HOLD, 8'hAA, 1, 8'h00, 0, 8, 1);
        add(1, M_RSVD, 8'hAA, 1, 8'h00, 0, 8, 1);
        // Reserved code holds, clear resets q/cnt/done
        add(1, M_LOAD, 8'h12, 0, 8'h12, 0, 0, 0);
        add(1, M_RSVD, 8'hEE, 1, 8'h12, 0, 0, 0);
        add(1, M_CLR,  8'hEE, 1, 8'h00, 0, 0, 0);
        // Clear also drops a set sout; serial input enters on shift left
        add(1, M_LOAD, 8'h81, 0, 8'h81, 0, 0, 0);
        add(1, M_SHR,  8'h00, 1, 8'hC0, 1, 1, 0);
        add(1, M_CLR,  8'h00, 0, 8'h00, 0, 0, 0);
        add(1, M_SHL,  8'h00, 1, 8'h01, 0, 1, 0);
        add(1, M_SHL,  8'h00, 1, 8'h03, 0, 2, 0);
        add(1, M_ROR,  8'h00, 0, 8'h81, 1, 3, 0);   // sin ignored

        // Reset is asynchronous: checked before any clock edge
        #2;
        check_all("reset_init", 8'h00, 0, 0, 0);
        #10;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].sin);
            check_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].sout,
                      vecs[i].cnt, vecs[i].done);
        end

        // Reset between edges in the middle of a shift run
        step(1, M_LOAD, 8'h5A, 0);
        step(1, M_SHL, 8'h00, 0);
        step(1, M_SHL, 8'h00, 0);
        check("midrun.sout2", 32'(sout), 32'd1);
        step(1, M_SHL, 8'h00, 0);
        check_all("midrun.pre", 8'hD0, 0, 3, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("midrun.rst", 8'h00, 0, 0, 0);

        // Inputs are ignored while reset is held across clock edges
        en = 1'b1; mode = M_LOAD; d = 8'hFF; sin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("rst_held", 8'h00, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        step(1, M_SHL, 8'h00, 1);
        check_all("post_rst", 8'h01, 0, 1, 0);

        // Reset while done and sout are high leaves nothing behind
        step(1, M_LOAD, 8'hFF, 0);
        repeat (8) step(1, M_SHR, 8'h00, 0);
        check_all("full_run", 8'h00, 1, 8, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("done_rst", 8'h00, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        step(1, M_HOLD, 8'h00, 0);
        check_all("no_residue", 8'h00, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ureg.md
UREG -- requirements
Module: ureg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; the block SHALL support WIDTH >= 2.
REQ-002 Parameter RST_VAL, default 0, WIDTH-bit value loaded into q on reset and on sync clear.
REQ-003 Derived CW = $clog2(WIDTH+1); the block SHALL size the count output to CW bits.
REQ-004 ureg_port_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 ureg_port_rst  in  1  reset, asynchronous, active-low.
REQ-006 ureg_port_en  in  1  operation enable; low SHALL freeze all state.
REQ-007 ureg_port_mode  in  3  operation select, decoded per REQ-011.
REQ-008 ureg_port_d  in  WIDTH  parallel load data.
REQ-009 ureg_port_sin  in  1  serial input bit for shift modes.
REQ-010 Outputs: ureg_oport_q out WIDTH register contents; ureg_oport_sout out 1 last bit shifted/rotated out; ureg_oport_cnt out CW shifts since last load/clear; ureg_oport_done out 1 high when cnt == WIDTH.

Function
REQ-011 The mode decode SHALL be: 000 hold, 001 parallel load, 010 shift left, 011 shift right, 100 rotate left, 101 rotate right, 110 sync clear, 111 hold (reserved).
REQ-012 With en high, all mode effects SHALL take effect at the next rising clk edge, with one-cycle latency to q, sout, cnt and done.
REQ-013 With en low, q, sout and cnt SHALL hold regardless of mode, d or sin.
REQ-014 Load SHALL set q <= d and cnt <= 0; sout SHALL hold.
REQ-015 Shift left SHALL set q <= {q[WIDTH-2:0], sin} and sout <= q[WIDTH-1].
REQ-016 Shift right SHALL set q <= {sin, q[WIDTH-1:1]} and sout <= q[0].
REQ-017 Rotate left SHALL set q <= {q[WIDTH-2:0], q[WIDTH-1]} and sout <= q[WIDTH-1]; sin SHALL be ignored.
REQ-018 Rotate right SHALL set q <= {q[0], q[WIDTH-1:1]} and sout <= q[0]; sin SHALL be ignored.
REQ-019 Each shift or rotate SHALL increment cnt by 1, saturating at WIDTH; no wrap to 0.
REQ-020 Sync clear SHALL set q <= RST_VAL, cnt <= 0 and sout <= 0.
REQ-021 Hold and reserved codes SHALL leave all state unchanged.
REQ-022 done SHALL be combinational from the cnt register (cnt == WIDTH) and SHALL stay high until load, clear or reset.
REQ-023 Shifts with cnt == WIDTH SHALL still move data and update sout; only cnt saturates.
REQ-024 Mode changes between consecutive enabled cycles SHALL need no idle cycle; each edge uses only the current mode.

Reset
REQ-025 Assertion of ureg_port_rst low SHALL immediately, without a clock edge, force q = RST_VAL, sout = 0, cnt = 0 and done = 0.
REQ-026 While reset is low, the block SHALL ignore en, mode, d and sin.
REQ-027 After reset deassertion, the first enabled clk edge SHALL execute the mode normally.
REQ-028 Reset asserted mid-sequence, such as during a shift run, SHALL abort the run with no residual state.

Verification (WIDTH=8, RST_VAL=0)
REQ-029 Bench SHALL load d=8'hA5, then shift left 8 times with sin=0 -> sout sequence 1,0,1,0,0,1,0,1, final q=8'h00, cnt=8, done=1.
REQ-030 Bench SHALL load 8'h81, then rotate right once -> q=8'hC0, sout=1, cnt=1; then rotate left once -> q=8'h81, sout=1, cnt=2.
REQ-031 Bench SHALL load 8'h3C, then hold en=0 for 5 cycles with mode=010 and toggling sin -> q=8'h3C, cnt=0 throughout.
REQ-032 Bench SHALL load 8'hFF, then shift right 10 times with sin=0 -> q=8'h00, cnt saturates at 8, done=1, sout=0 on cycles 9-10.
REQ-033 Bench SHALL load 8'h5A, shift left 3 times, then drive rst low between clock edges -> q=8'h00, cnt=0, sout=0 before the next edge.
REQ-034 Bench SHALL load 8'h12, then apply mode 111 and then mode 110 -> q=8'h12 after 111, then q=8'h00, cnt=0, done=0 after 110.
